fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
//   Generates select codes for the 16-bit ALU operand 3:1 muxes (00 regfile, 01 EX/MEM, 10 MEM/WB).
//   Detects load-use hazards and issues stall/bubble controls for the 5-stage pipeline.
//   Keeps its own shadow copy of dest/regwrite/load info for the EX, MEM and WB stages.
//   Sits beside the ID/EX register; its sel outputs drive the EX-stage operand muxes.
// PARAMETERS
//   REG_AW    3   register address width (8 GPRs; r0 hard-wired zero)
//   CNT_W     16  stall performance counter width
// PORTS
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   id_valid     in   1      ID stage holds a real instruction
//   id_rs        in   REG_AW ID source register A
//   id_rt        in   REG_AW ID source register B
//   id_use_rs    in   1      ID instruction reads rs
//   id_use_rt    in   1      ID instruction reads rt
//   id_reg_write in   1      ID instruction writes a register
//   id_dest      in   REG_AW ID destination register
//   id_is_load   in   1      ID instruction is LW
//   flush        in   1      taken branch/jump resolved; squash ID
//   fwd_a_sel    out  2      EX operand-A mux select
//   fwd_b_sel    out  2      EX operand-B mux select
//   stall        out  1      load-use stall this cycle
//   pc_write     out  1      PC update enable (= ~stall)
//   ifid_write   out  1      IF/ID register enable (= ~stall)
//   idex_bubble  out  1      insert NOP into ID/EX (= stall | flush)
//   stall_cnt    out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//   Reset: all shadow stages invalid, regwrite=0, dest=0; stall_cnt=0; fwd_*_sel=00,
//     stall=0, pc_write=1, ifid_write=1, idex_bubble=0 while rst high and first cycle after.
//   Shadow pipe per edge: WB<=MEM, MEM<=EX; EX<=ID fields (rs,rt,use,dest,regwrite,load)
//     when id_valid & ~idex_bubble, else EX<=bubble (valid=0, regwrite=0, load=0).
//   Forwarding (combinational from registered EX rs/rt vs MEM/WB), per operand X in {rs,rt}:
//     01 if MEM.regwrite & MEM.dest!=0 & MEM.dest==EX.X & EX.use_X;
//     else 10 if WB.regwrite & WB.dest!=0 & WB.dest==EX.X & EX.use_X; else 00.
//     MEM priority over WB (youngest result wins). 11 never driven. r0 never forwarded.
//   Load-use: stall = EX.valid & EX.load & EX.dest!=0 & id_valid &
//     ((id_use_rs & id_rs==EX.dest) | (id_use_rt & id_rt==EX.dest)) & ~flush.
//     Exactly one stall cycle per hazard: after the bubble, load is in MEM -> sel 01... load
//     data arrives via MEM/WB next cycle -> sel 10 for dependent instruction.
//   flush priority over stall: stall=0, EX<=bubble, ID fields ignored that edge.
//   Forwarded-from-load in MEM is never selected (stall guarantees it); no extra check.
//   stall_cnt increments on each edge with stall=1; saturates at all-ones, no wrap.
//   Async reset mid-stall: stall drops immediately, shadow stages cleared, counter 0.
// TESTING
//   ADD r1 then ADD r2,r1,r3 back-to-back -> 2nd in EX: fwd_a_sel=01, fwd_b_sel=00, stall=0.
//   ADD r1; NOP; SUB r4,r3,r1 -> SUB in EX: fwd_b_sel=10; write r1 in both MEM and WB -> 01.
//   LW r2; ADD r5,r2,r2 -> 1 cycle stall=1, pc_write=0, idex_bubble=1; then ADD in EX sel A/B=10.
//   Writes to r0 (ADDI r0) followed by reader of r0 -> sels 00, stall 0 even for LW r0.
//   LW r2 with ADD r2 dependent while flush=1 -> stall=0, idex_bubble=1, stall_cnt unchanged.
//   Force 2^16+3 stall cycles -> stall_cnt holds 16'hFFFF; assert rst mid-stall -> all outputs reset values at once.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding select and load-use hazard control for a 5-stage pipeline.
// Latency: sel/stall are combinational from shadow EX/MEM/WB state plus ID inputs.
// Backpressure: stall drops pc_write/ifid_write and bubbles ID/EX for exactly one cycle.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_reg_write,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  // EX needs source info for forwarding compares and the load flag for hazard detection.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_rs;
    logic              use_rt;
    logic [REG_AW-1:0] dest;
    logic              reg_write;
    logic              is_load;
  } ex_stage_t;

  // MEM/WB only act as forwarding sources; a bubble is simply reg_write=0.
  // The load flag is not carried: a load result in MEM can never be the
  // selected source because the one-cycle stall moves the consumer past it.
  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic              reg_write;
  } wr_stage_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_stage_t ex_q;
  ex_stage_t id_stage;
  wr_stage_t mem_q;
  wr_stage_t wb_q;
  logic      hit_rs;
  logic      hit_rt;

  // Youngest producer wins; r0 is never forwarded since it always reads zero.
  function automatic logic [1:0] pick_src(
    input logic [REG_AW-1:0] src,
    input logic              use_src,
    input wr_stage_t         mem_s,
    input wr_stage_t         wb_s
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (use_src && mem_s.reg_write && (mem_s.dest != '0) && (mem_s.dest == src)) begin
      sel = SEL_MEM;
    end else if (use_src && wb_s.reg_write && (wb_s.dest != '0) && (wb_s.dest == src)) begin
      sel = SEL_WB;
    end
    return sel;
  endfunction

  // Operand mux selects for the instruction currently in EX.
  always_comb begin
    fwd_a_sel = pick_src(ex_q.rs, ex_q.use_rs, mem_q, wb_q);
    fwd_b_sel = pick_src(ex_q.rt, ex_q.use_rt, mem_q, wb_q);
  end

  // Load in EX feeding the instruction in ID needs one bubble; flush overrides.
  always_comb begin
    hit_rs      = id_use_rs && (id_rs == ex_q.dest);
    hit_rt      = id_use_rt && (id_rt == ex_q.dest);
    stall       = ex_q.valid && ex_q.is_load && (ex_q.dest != '0) && id_valid &&
                  (hit_rs || hit_rt) && !flush;
    pc_write    = !stall;
    ifid_write  = !stall;
    idex_bubble = stall || flush;
  end

  // Pack the ID fields into the shape the EX shadow holds.
  always_comb begin
    id_stage.valid     = 1'b1;
    id_stage.rs        = id_rs;
    id_stage.rt        = id_rt;
    id_stage.use_rs    = id_use_rs;
    id_stage.use_rt    = id_use_rt;
    id_stage.dest      = id_dest;
    id_stage.reg_write = id_reg_write;
    id_stage.is_load   = id_is_load;
  end

  // Advance the shadow pipe; a bubble clears every EX field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q            <= (id_valid && !idex_bubble) ? id_stage : '0;
      mem_q.dest      <= ex_q.dest;
      mem_q.reg_write <= ex_q.reg_write;
      wb_q            <= mem_q;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed scoreboard bench for fwd_hazard_ctrl.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
// A second narrow-counter instance exercises counter saturation in few cycles.
module tb_fwd_hazard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       wr;
    logic [2:0] dest;
    logic       load;
  } ins_t;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic        pcw;
    logic        ifw;
    logic        bub;
    logic [15:0] cnt;
    logic [1:0]  sfa;
    logic [1:0]  sfb;
    logic        sst;
    logic        spcw;
    logic        sifw;
    logic        sbub;
    logic [7:0]  scnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  ins_t        cur = '0;
  logic        flush = 1'b0;
  logic        chk = 1'b0;

  logic [1:0]  fwd_a_sel, fwd_b_sel, s_fa, s_fb;
  logic        stall, pc_write, ifid_write, idex_bubble;
  logic        s_st, s_pcw, s_ifw, s_bub;
  logic [15:0] stall_cnt;
  logic [7:0]  s_cnt;

  obs_t  sb_q[$];
  string nm_q[$];
  int    nvec = 0;
  int    nfail = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(cur.valid), .id_rs(cur.rs), .id_rt(cur.rt),
    .id_use_rs(cur.use_rs), .id_use_rt(cur.use_rt), .id_reg_write(cur.wr),
    .id_dest(cur.dest), .id_is_load(cur.load), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble), .stall_cnt(stall_cnt)
  );

  fwd_hazard_ctrl #(.REG_AW(3), .CNT_W(8)) dut_s (
    .clk(clk), .rst(rst), .id_valid(cur.valid), .id_rs(cur.rs), .id_rt(cur.rt),
    .id_use_rs(cur.use_rs), .id_use_rt(cur.use_rt), .id_reg_write(cur.wr),
    .id_dest(cur.dest), .id_is_load(cur.load), .flush(flush),
    .fwd_a_sel(s_fa), .fwd_b_sel(s_fb), .stall(s_st), .pc_write(s_pcw),
    .ifid_write(s_ifw), .idex_bubble(s_bub), .stall_cnt(s_cnt)
  );

  function automatic ins_t nop();
    return '0;
  endfunction

  function automatic ins_t alu(input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    ins_t i;
    i = '0; i.valid = 1'b1; i.rs = a; i.rt = b; i.use_rs = 1'b1; i.use_rt = 1'b1;
    i.wr = 1'b1; i.dest = d;
    return i;
  endfunction

  function automatic ins_t addi(input logic [2:0] d, input logic [2:0] a);
    ins_t i;
    i = '0; i.valid = 1'b1; i.rs = a; i.use_rs = 1'b1; i.wr = 1'b1; i.dest = d;
    return i;
  endfunction

  function automatic ins_t lw(input logic [2:0] d, input logic [2:0] base);
    ins_t i;
    i = addi(d, base); i.load = 1'b1;
    return i;
  endfunction

  // Both instances share stimulus; only the narrow counter's value differs.
  function automatic obs_t ex(input logic [1:0] fa, input logic [1:0] fb,
                              input logic st, input logic bub, input int cnt);
    obs_t e;
    e.fa = fa; e.fb = fb; e.st = st; e.pcw = ~st; e.ifw = ~st; e.bub = bub;
    e.cnt = 16'(cnt);
    e.sfa = fa; e.sfb = fb; e.sst = st; e.spcw = ~st; e.sifw = ~st; e.sbub = bub;
    e.scnt = (cnt > 255) ? 8'hFF : 8'(cnt);
    return e;
  endfunction

  // Drive one ID slot at posedge+1, optionally queue its expectation, advance one edge.
  task automatic apply(input ins_t i, input logic fl, input logic do_chk,
                       input obs_t e, input string nm);
    cur = i;
    flush = fl;
    if (do_chk) begin
      sb_q.push_back(e);
      nm_q.push_back(nm);
    end
    chk = do_chk;
    @(posedge clk);
    #1;
  endtask

  // Compare whatever the DUTs present mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (chk) begin
      obs_t a, x;
      string n;
      a = {fwd_a_sel, fwd_b_sel, stall, pc_write, ifid_write, idex_bubble, stall_cnt,
           s_fa, s_fb, s_st, s_pcw, s_ifw, s_bub, s_cnt};
      nvec++;
      if (sb_q.size() == 0) begin
        nfail++;
        $display("FAIL no_expectation: got %h, nothing queued", a);
      end else begin
        x = sb_q.pop_front();
        n = nm_q.pop_front();
        if (a !== x) begin
          nfail++;
          $display("FAIL %s: got fa=%b fb=%b st=%b pcw=%b ifw=%b bub=%b cnt=%h scnt=%h | want fa=%b fb=%b st=%b pcw=%b ifw=%b bub=%b cnt=%h scnt=%h",
                   n, a.fa, a.fb, a.st, a.pcw, a.ifw, a.bub, a.cnt, a.scnt,
                   x.fa, x.fb, x.st, x.pcw, x.ifw, x.bub, x.cnt, x.scnt);
        end
      end
    end
  end

  initial begin
    obs_t dflt;
    dflt = ex(2'b00, 2'b00, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    // Reset held with a hazard-looking ID word: outputs must stay at reset values.
    apply(alu(3'd5, 3'd2, 3'd2), 1'b0, 1'b1, dflt, "rst_hold");
    rst = 1'b0;
    apply(nop(), 1'b0, 1'b1, dflt, "rst_first_cycle");

    // ADD r1 ; ADD r2,r1,r3 -> MEM forward on A.
    apply(alu(3'd1, 3'd2, 3'd3), 1'b0, 1'b1, dflt, "add_r1_issue");
    apply(alu(3'd2, 3'd1, 3'd3), 1'b0, 1'b1, dflt, "add_dep_issue");
    apply(nop(), 1'b0, 1'b1, ex(2'b01, 2'b00, 1'b0, 1'b0, 0), "mem_fwd_a");

    // ADD r1 ; NOP ; SUB r4,r3,r1 -> WB forward on B.
    apply(alu(3'd1, 3'd5, 3'd6), 1'b0, 1'b0, dflt, "");
    apply(nop(), 1'b0, 1'b0, dflt, "");
    apply(alu(3'd4, 3'd3, 3'd1), 1'b0, 1'b0, dflt, "");
    apply(nop(), 1'b0, 1'b1, ex(2'b00, 2'b10, 1'b0, 1'b0, 0), "wb_fwd_b");

    // r1 written by both MEM and WB producers -> MEM wins on both operands.
    apply(alu(3'd1, 3'd2, 3'd2), 1'b0, 1'b0, dflt, "");
    apply(alu(3'd1, 3'd3, 3'd3), 1'b0, 1'b0, dflt, "");
    apply(alu(3'd7, 3'd1, 3'd1), 1'b0, 1'b0, dflt, "");
    apply(nop(), 1'b0, 1'b1, ex(2'b01, 2'b01, 1'b0, 1'b0, 0), "mem_over_wb");

    // LW r2 ; ADD r5,r2,r2 -> one stall, then WB forward on both operands.
    apply(lw(3'd2, 3'd3), 1'b0, 1'b0, dflt, "");
    apply(alu(3'd5, 3'd2, 3'd2), 1'b0, 1'b1, ex(2'b00, 2'b00, 1'b1, 1'b1, 0), "load_use_stall");
    apply(alu(3'd5, 3'd2, 3'd2), 1'b0, 1'b1, ex(2'b00, 2'b00, 1'b0, 1'b0, 1), "stall_released");
    apply(nop(), 1'b0, 1'b1, ex(2'b10, 2'b10, 1'b0, 1'b0, 1), "load_wb_fwd");

    // r0 destinations never stall and never forward.
    apply(lw(3'd0, 3'd3), 1'b0, 1'b0, dflt, "");
    apply(alu(3'd6, 3'd0, 3'd0), 1'b0, 1'b1, ex(2'b00, 2'b00, 1'b0, 1'b0, 1), "lw_r0_nostall");
    apply(addi(3'd0, 3'd0), 1'b0, 1'b1, ex(2'b00, 2'b00, 1'b0, 1'b0, 1), "r0_mem_nofwd");
    apply(alu(3'd6, 3'd0, 3'd0), 1'b0, 1'b0, dflt, "");
    apply(nop(), 1'b0, 1'b1, ex(2'b00, 2'b00, 1'b0, 1'b0, 1), "r0_mem_wb_nofwd");

    // Flush beats stall; the flushed ADD must not reach EX.
    apply(lw(3'd2, 3'd3), 1'b0, 1'b0, dflt, "");
    apply(alu(3'd5, 3'd2, 3'd2), 1'b1, 1'b1, ex(2'b00, 2'b00, 1'b0, 1'b1, 1), "flush_over_stall");
    apply(nop(), 1'b0, 1'b1, ex(2'b00, 2'b00, 1'b0, 1'b0, 1), "flushed_not_in_ex");

    // Matching registers that are not read, or an invalid ID slot, never stall.
    apply(lw(3'd4, 3'd3), 1'b0, 1'b0, dflt, "");
    begin
      ins_t i;
      i = '0; i.valid = 1'b1; i.rs = 3'd4; i.rt = 3'd4;
      apply(i, 1'b0, 1'b1, ex(2'b00, 2'b00, 1'b0, 1'b0, 1), "unused_src_nostall");
      apply(lw(3'd4, 3'd3), 1'b0, 1'b0, dflt, "");
      i = addi(3'd5, 3'd4); i.valid = 1'b0;
      apply(i, 1'b0, 1'b1, ex(2'b00, 2'b00, 1'b0, 1'b0, 1), "invalid_id_nostall");
    end

    // Repeated load-use hazards drive the narrow counter into saturation.
    for (int k = 0; k < 258; k++) begin
      apply(lw(3'd2, 3'd3), 1'b0, 1'b0, dflt, "");
      apply(alu(3'd5, 3'd2, 3'd2), 1'b0, 1'b1, ex(2'b00, 2'b00, 1'b1, 1'b1, 1 + k), "stall_count");
    end

    // Reset asserted in the middle of a stall cycle.
    apply(lw(3'd2, 3'd3), 1'b0, 1'b0, dflt, "");
    cur = alu(3'd5, 3'd2, 3'd2);
    flush = 1'b0;
    sb_q.push_back(ex(2'b00, 2'b00, 1'b1, 1'b1, 259));
    nm_q.push_back("stall_before_rst");
    chk = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    sb_q.push_back(dflt);
    nm_q.push_back("rst_mid_stall");
    @(negedge clk);
    #1;
    chk = 1'b0;
    rst = 1'b0;
    cur = nop();
    repeat (2) @(posedge clk);

    if (sb_q.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
